// File: rtl/stopwatch_button_ctrl.sv
// stopwatch_button_ctrl: synchronises and debounces the start/stop and reset buttons
// and turns them into one-cycle start/stop/reset command pulses for the control FSM.
module stopwatch_button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_ss,
    input  logic btn_rst,
    input  logic running,
    output logic start,
    output logic stop,
    output logic reset
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HELD = 2'd1;
    localparam logic [1:0] LONG = 2'd2;

    // Bit 0 is btn_ss, bit 1 is btn_rst throughout the input path.
    logic [1:0]         sync1_q, sync1_d, sync2_q, sync2_d, db_q, db_d;
    logic [1:0][DW-1:0] cnt_q, cnt_d;
    logic               rst_prev_q, rst_prev_d;
    logic [1:0]         state_q, state_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic               start_q, start_d, stop_q, stop_d, reset_q, reset_d;
    logic               long_hit, short_rel, rst_rise;

    always_comb begin
        sync1_d = {btn_rst, btn_ss};
        sync2_d = sync1_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            db_d[i]  = db_q[i];
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1))
                    db_d[i] = ~db_q[i];
                else
                    cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        rst_prev_d = db_q[1];
        rst_rise   = db_q[1] & ~rst_prev_q;
        state_d    = state_q;
        hold_d     = hold_q;
        long_hit   = 1'b0;
        short_rel  = 1'b0;
        case (state_q)
            IDLE: if (db_q[0]) begin
                state_d = HELD;
                hold_d  = '0;
            end
            HELD: if (!db_q[0]) begin
                state_d   = IDLE;
                short_rel = 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HW'(LONG_CYCLES - 1)) begin
                    state_d  = LONG;
                    long_hit = 1'b1;
                end
            end
            LONG: if (!db_q[0]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A coinciding reset cause swallows the short-press command outright.
        reset_d = rst_rise | long_hit;
        start_d = short_rel & ~reset_d & ~running;
        stop_d  = short_rel & ~reset_d & running;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_q       <= '0;
            cnt_q      <= '0;
            rst_prev_q <= 1'b0;
            state_q    <= IDLE;
            hold_q     <= '0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            reset_q    <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_q       <= db_d;
            cnt_q      <= cnt_d;
            rst_prev_q <= rst_prev_d;
            state_q    <= state_d;
            hold_q     <= hold_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            reset_q    <= reset_d;
        end
    end

    assign start = start_q;
    assign stop  = stop_q;
    assign reset = reset_q;
endmodule

// File: tb/tb_stopwatch_button_ctrl.sv
// tb_stopwatch_button_ctrl: directed scenarios plus random button traffic, checked
// against an edge-indexed model of the debounce and press-length rules.
module tb_stopwatch_button_ctrl;
    localparam int D = 4;
    localparam int L = 16;

    logic clk = 1'b0, rst_n = 1'b0, btn_ss = 1'b0, btn_rst = 1'b0, running = 1'b0;
    logic start, stop, reset;
    int   checks = 0, failures = 0;

    stopwatch_button_ctrl #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
        .clk(clk), .rst_n(rst_n), .btn_ss(btn_ss), .btn_rst(btn_rst),
        .running(running), .start(start), .stop(stop), .reset(reset)
    );

    always #5 clk = ~clk;

    // Model: a debounced level flips once the last D synced samples all disagree with it.
    int         k = 0, rise_t = -1000;
    logic [1:0] m_s1, m_s2, m_db;
    logic [D-1:0] h_ss, h_rst;
    bit         pressed, long_fired, ss_fell, rst_rose;
    logic [2:0] exp_o;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0; h_ss = '0; h_rst = '0;
        pressed = 0; long_fired = 0; ss_fell = 0; rst_rose = 0; exp_o = '0;
    endtask

    task automatic step();
        logic [1:0] raw, nd;
        logic run;
        bit r, sh;
        raw = {btn_rst, btn_ss};
        run = running;
        @(posedge clk);
        k++;
        if (!rst_n) begin
            model_reset();
        end else begin
            r  = rst_rose || (pressed && !long_fired && m_db[0] && (k - 1 == rise_t + L));
            sh = pressed && !long_fired && ss_fell;
            exp_o = {sh && !r && !run, sh && !r && run, r};
            if (r && !rst_rose) long_fired = 1;
            if (ss_fell) pressed = 0;
            h_ss  = {h_ss[D-2:0], m_s2[0]};
            h_rst = {h_rst[D-2:0], m_s2[1]};
            nd = m_db;
            if (h_ss == {D{~m_db[0]}}) nd[0] = ~m_db[0];
            if (h_rst == {D{~m_db[1]}}) nd[1] = ~m_db[1];
            ss_fell  = m_db[0] && !nd[0];
            rst_rose = !m_db[1] && nd[1];
            if (!m_db[0] && nd[0]) begin
                pressed = 1; long_fired = 0; rise_t = k;
            end
            m_db = nd;
            m_s2 = m_s1;
            m_s1 = raw;
        end
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        repeat (3) begin
            step();
            checks++;
            if ({start, stop, reset} !== 3'b000) begin
                failures++;
                $display("FAIL reset_state cyc=%0d got=%b want=000", k, {start, stop, reset});
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_bounce();
        int p = 0;
        btn_ss = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 3) btn_ss = 1'b0;
            step();
            p += int'(start) + int'(stop) + int'(reset);
            checks++;
            if ({start, stop, reset} !== exp_o) begin
                failures++;
                $display("FAIL bounce_model cyc=%0d got=%b want=%b", k, {start, stop, reset}, exp_o);
            end
        end
        checks++;
        if (p != 0) begin
            failures++;
            $display("FAIL bounce_pulses got=%0d want=0", p);
        end
    endtask

    task automatic test_short(input logic run_lvl, input string name);
        int n_rel = 0, hit = 0, hit_edge = -1, p = 0;
        running = run_lvl;
        btn_ss = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) btn_ss = 1'b0;
            step();
            if (i == 10) n_rel = k;
            if (run_lvl ? stop : start) begin hit++; hit_edge = k; end
            p += int'(start) + int'(stop) + int'(reset);
            checks++;
            if ({start, stop, reset} !== exp_o) begin
                failures++;
                $display("FAIL %s_model cyc=%0d got=%b want=%b", name, k, {start, stop, reset}, exp_o);
            end
        end
        checks++;
        if (hit != 1 || p != 1 || hit_edge != n_rel + 6) begin
            failures++;
            $display("FAIL %s_pulse got=%0d/%0d@%0d want=1/1@%0d", name, hit, p, hit_edge, n_rel + 6);
        end
    endtask

    task automatic test_long_press();
        int n0 = 0, hit = 0, hit_edge = -1, ss_p = 0;
        running = 1'b0;
        btn_ss = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (i == 40) btn_ss = 1'b0;
            step();
            if (i == 0) n0 = k;
            if (reset) begin hit++; hit_edge = k; end
            ss_p += int'(start) + int'(stop);
            checks++;
            if ({start, stop, reset} !== exp_o) begin
                failures++;
                $display("FAIL long_model cyc=%0d got=%b want=%b", k, {start, stop, reset}, exp_o);
            end
        end
        checks++;
        if (hit != 1 || ss_p != 0 || hit_edge != n0 + 5 + 17) begin
            failures++;
            $display("FAIL long_pulse got=%0d/%0d@%0d want=1/0@%0d", hit, ss_p, hit_edge, n0 + 22);
        end
    endtask

    task automatic test_simultaneous();
        int hit = 0, ss_p = 0;
        running = 1'b0;
        btn_ss = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) begin btn_ss = 1'b0; btn_rst = 1'b1; end
            if (i == 25) btn_rst = 1'b0;
            step();
            hit += int'(reset);
            ss_p += int'(start) + int'(stop);
            checks++;
            if ({start, stop, reset} !== exp_o) begin
                failures++;
                $display("FAIL simul_model cyc=%0d got=%b want=%b", k, {start, stop, reset}, exp_o);
            end
        end
        checks++;
        if (hit != 1 || ss_p != 0) begin
            failures++;
            $display("FAIL simul_pulse reset=%0d startstop=%0d want=1/0", hit, ss_p);
        end
    endtask

    task automatic test_async_reset();
        int seen = 0, p = 0, n0 = 0, hit = 0, hit_edge = -1;
        btn_rst = 1'b1;
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            if (reset) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL async_setup reset pulse not seen within 30 cycles");
        end
        btn_rst = 1'b0;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({start, stop, reset} !== 3'b000) begin
            failures++;
            $display("FAIL async_clear got=%b want=000", {start, stop, reset});
        end
        repeat (2) step();
        rst_n = 1'b1;
        repeat (10) step();
        // Press, reset at hold_cnt=8, release during reset: nothing afterwards.
        btn_ss = 1'b1;
        repeat (15) step();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({start, stop, reset} !== 3'b000) begin
            failures++;
            $display("FAIL midhold_clear got=%b want=000", {start, stop, reset});
        end
        btn_ss = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            p += int'(start) + int'(stop) + int'(reset);
            checks++;
            if ({start, stop, reset} !== exp_o) begin
                failures++;
                $display("FAIL released_model cyc=%0d got=%b want=%b", k, {start, stop, reset}, exp_o);
            end
        end
        checks++;
        if (p != 0) begin
            failures++;
            $display("FAIL released_pulses got=%0d want=0", p);
        end
        // Press kept held through reset: fresh long press.
        btn_ss = 1'b1;
        repeat (15) step();
        #2 rst_n = 1'b0;
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        p = 0;
        for (int i = 0; i < 70; i++) begin
            if (i == 35) btn_ss = 1'b0;
            step();
            if (i == 0) n0 = k;
            if (reset) begin hit++; hit_edge = k; end
            p += int'(start) + int'(stop);
            checks++;
            if ({start, stop, reset} !== exp_o) begin
                failures++;
                $display("FAIL held_model cyc=%0d got=%b want=%b", k, {start, stop, reset}, exp_o);
            end
        end
        checks++;
        if (hit != 1 || p != 0 || hit_edge != n0 + 22) begin
            failures++;
            $display("FAIL held_pulse got=%0d/%0d@%0d want=1/0@%0d", hit, p, hit_edge, n0 + 22);
        end
    endtask

    task automatic test_random();
        int seg;
        for (int s = 0; s < 250; s++) begin
            btn_ss  = ($urandom_range(0, 2) != 0);
            btn_rst = ($urandom_range(0, 5) == 0);
            running = 1'($urandom);
            seg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 30));
            repeat (seg) begin
                step();
                checks++;
                if ({start, stop, reset} !== exp_o) begin
                    failures++;
                    $display("FAIL random_model cyc=%0d got=%b want=%b", k, {start, stop, reset}, exp_o);
                end
                if (int'(start) + int'(stop) + int'(reset) > 1) begin
                    failures++;
                    $display("FAIL onehot cyc=%0d got=%b want<=1 high", k, {start, stop, reset});
                end
            end
        end
        btn_ss = 1'b0;
        btn_rst = 1'b0;
        repeat (40) step();
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_short(1'b0, "short_start");
        test_short(1'b1, "short_stop");
        test_long_press();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
